// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer for a synchronous instruction ROM with a one-cycle read.
// Owns the PC and presents each instruction with its PC over valid/stall.
module instr_fetch_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int INSTR_W   = 8,
  parameter int RESET_PC  = 0,
  parameter int LAST_ADDR = 255
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Stall,
  input  logic               Halt,
  input  logic               Redirect,
  input  logic [ADDR_W-1:0]  RedirectAddr,
  output logic [ADDR_W-1:0]  RomAddress,
  input  logic [INSTR_W-1:0] RomData,
  output logic [INSTR_W-1:0] Instruction,
  output logic [ADDR_W-1:0]  InstrPC,
  output logic               InstrValid,
  output logic               Busy,
  output logic               Done
);

  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_END = ADDR_W'(LAST_ADDR);
  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALTED,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  logic              pending_q, pending_d;

  logic run;
  logic valid;
  logic accept;
  logic held;

  assign run    = state_q == S_RUN;
  assign valid  = run & pending_q & ~Redirect;
  assign accept = valid & ~Stall;
  assign held   = run & pending_q & Stall;

  assign InstrValid  = valid;
  assign Instruction = valid ? RomData : '0;
  assign InstrPC     = pend_q;
  assign Busy        = run;
  assign Done        = state_q == S_DONE;

  // A held instruction is re-read so RomData stays stable under stall.
  always_comb begin
    RomAddress = pc_q;
    if (run && Redirect) begin
      RomAddress = RedirectAddr;
    end else if (held) begin
      RomAddress = pend_q;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      pc_q      <= PC_RST;
      pend_q    <= PC_RST;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d   = S_RUN;
          pending_d = 1'b1;
          pend_d    = PC_RST;
          pc_d      = PC_RST + PC_ONE;
        end
      end
      S_HALTED: begin
        if (Start) begin
          state_d   = S_RUN;
          pending_d = 1'b1;
          pend_d    = pc_q;
          pc_d      = pc_q + PC_ONE;
        end
      end
      S_RUN: begin
        if (Halt) begin
          state_d   = S_HALTED;
          pending_d = 1'b0;
          if (Redirect) begin
            pc_d = RedirectAddr;
          end else if (accept || !pending_q) begin
            pc_d = pc_q;
          end else begin
            pc_d = pend_q;
          end
        end else if (Redirect) begin
          pending_d = 1'b1;
          pend_d    = RedirectAddr;
          pc_d      = RedirectAddr + PC_ONE;
        end else if (accept && pend_q == PC_END) begin
          // Park the PC at the restart address so Start re-issues it.
          state_d   = S_DONE;
          pending_d = 1'b0;
          pc_d      = PC_RST;
        end else if (held) begin
          pc_d = pc_q;
        end else begin
          pending_d = 1'b1;
          pend_d    = pc_q;
          pc_d      = pc_q + PC_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a cycle-level reference model
// of the fetch stream compared against the DUT on every cycle.
module tb_instr_fetch_ctrl;

  logic       Clock;
  logic       Reset;
  logic       Start;
  logic       Stall;
  logic       Halt;
  logic       Redirect;
  logic [7:0] RedirectAddr;
  logic [7:0] RomAddress;
  logic [7:0] RomData;
  logic [7:0] Instruction;
  logic [7:0] InstrPC;
  logic       InstrValid;
  logic       Busy;
  logic       Done;

  instr_fetch_ctrl #(
    .ADDR_W   (8),
    .INSTR_W  (8),
    .RESET_PC (0),
    .LAST_ADDR(37)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .Stall       (Stall),
    .Halt        (Halt),
    .Redirect    (Redirect),
    .RedirectAddr(RedirectAddr),
    .RomAddress  (RomAddress),
    .RomData     (RomData),
    .Instruction (Instruction),
    .InstrPC     (InstrPC),
    .InstrValid  (InstrValid),
    .Busy        (Busy),
    .Done        (Done)
  );

  logic [7:0] rom [256];

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i * 7 + 3);
    rom[0] = 8'h00; rom[1] = 8'h0A; rom[2] = 8'h68; rom[3] = 8'h0B;
    rom[4] = 8'h69; rom[5] = 8'h0B; rom[6] = 8'h6A; rom[7] = 8'h04;
    rom[8'h11] = 8'hD5;
    rom[8'h12] = 8'h67;
    rom[37] = 8'hE0;
  end

  initial RomData = 8'h00;
  always @(posedge Clock) RomData <= rom[RomAddress];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stream of addresses the fetch unit owes the
  // consumer, with the modes IDLE/RUN/HALTED/DONE.
  localparam int M_IDLE = 0;
  localparam int M_RUN = 1;
  localparam int M_HALT = 2;
  localparam int M_DONE = 3;
  localparam int LAST = 37;

  int mode = M_IDLE;
  int nxt = 0;
  int hold = 0;
  bit owed = 0;
  bit m_ready = 0;

  always @(posedge Clock) begin
    bit v;
    bit acc;
    if (Reset) begin
      mode = M_IDLE; nxt = 0; hold = 0; owed = 0; m_ready = 1;
    end else if (m_ready) begin
      v = (mode == M_RUN) && owed && !Redirect;
      acc = v && !Stall;
      case (mode)
        M_IDLE, M_DONE: if (Start) begin
          mode = M_RUN; hold = 0; nxt = 1; owed = 1;
        end
        M_HALT: if (Start) begin
          mode = M_RUN; hold = nxt; nxt = (nxt + 1) % 256; owed = 1;
        end
        default: begin
          if (Halt) begin
            if (Redirect) nxt = int'(RedirectAddr);
            else if (!(acc || !owed)) nxt = hold;
            owed = 0; mode = M_HALT;
          end else if (Redirect) begin
            hold = int'(RedirectAddr); nxt = (hold + 1) % 256; owed = 1;
          end else if (acc && hold == LAST) begin
            mode = M_DONE; owed = 0;
          end else if (!(owed && Stall)) begin
            hold = nxt; nxt = (nxt + 1) % 256; owed = 1;
          end
        end
      endcase
    end
  end

  always @(negedge Clock) begin
    bit ev;
    int ea;
    if (m_ready) begin
      ev = (mode == M_RUN) && owed && !Redirect;
      if (mode == M_RUN && Redirect) ea = int'(RedirectAddr);
      else if (mode == M_RUN && owed && Stall) ea = hold;
      else ea = nxt;
      chk("model_valid", int'(InstrValid), int'(ev));
      chk("model_instr", int'(Instruction), ev ? int'(rom[hold]) : 0);
      chk("model_pc", int'(InstrPC), hold);
      chk("model_busy", int'(Busy), int'(mode == M_RUN));
      chk("model_done", int'(Done), int'(mode == M_DONE));
      if (mode != M_DONE) chk("model_addr", int'(RomAddress), ea);
    end
  end

  task automatic cyc(input logic r, input logic s, input logic st,
                     input logic h, input logic rd, input logic [7:0] a);
    @(posedge Clock);
    #1;
    Reset = r; Start = s; Stall = st; Halt = h;
    Redirect = rd; RedirectAddr = a;
    @(negedge Clock);
  endtask

  initial begin
    Reset = 1; Start = 0; Stall = 0; Halt = 0;
    Redirect = 0; RedirectAddr = 8'h00;

    cyc(1, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 8'h00);
    chk("rst_addr", int'(RomAddress), 0);
    chk("rst_instr", int'(Instruction), 0);
    chk("rst_pc", int'(InstrPC), 0);
    chk("rst_valid", int'(InstrValid), 0);
    chk("rst_busy", int'(Busy), 0);
    chk("rst_done", int'(Done), 0);

    cyc(0, 1, 0, 0, 0, 8'h00);
    chk("start_addr", int'(RomAddress), 0);
    chk("start_valid", int'(InstrValid), 0);
    cyc(0, 0, 0, 0, 0, 8'h00);
    chk("c1_valid", int'(InstrValid), 1);
    chk("c1_pc", int'(InstrPC), 0);
    chk("c1_instr", int'(Instruction), 8'h00);
    cyc(0, 0, 0, 0, 0, 8'h00);
    chk("c2_pc", int'(InstrPC), 1);
    chk("c2_instr", int'(Instruction), 8'h0A);

    cyc(0, 0, 1, 0, 0, 8'h00);
    chk("c3_pc", int'(InstrPC), 2);
    chk("c3_instr", int'(Instruction), 8'h68);
    chk("stall_addr", int'(RomAddress), 2);
    cyc(0, 0, 1, 0, 0, 8'h00);
    chk("stall2_instr", int'(Instruction), 8'h68);
    chk("stall2_addr", int'(RomAddress), 2);
    cyc(0, 0, 1, 0, 0, 8'h00);
    chk("stall3_instr", int'(Instruction), 8'h68);
    cyc(0, 0, 0, 0, 0, 8'h00);
    chk("unstall_pc", int'(InstrPC), 2);
    cyc(0, 0, 0, 0, 0, 8'h00);
    chk("after_stall_pc", int'(InstrPC), 3);
    chk("after_stall_instr", int'(Instruction), 8'h0B);
    cyc(0, 0, 0, 0, 0, 8'h00);
    chk("pc4_instr", int'(Instruction), 8'h69);

    cyc(0, 0, 0, 0, 1, 8'h11);
    chk("redir_squash", int'(InstrValid), 0);
    chk("redir_addr", int'(RomAddress), 8'h11);
    cyc(0, 0, 0, 0, 0, 8'h00);
    chk("tgt0_pc", int'(InstrPC), 8'h11);
    chk("tgt0_instr", int'(Instruction), 8'hD5);
    cyc(0, 0, 0, 0, 0, 8'h00);
    chk("tgt1_pc", int'(InstrPC), 8'h12);
    chk("tgt1_instr", int'(Instruction), 8'h67);

    cyc(0, 0, 0, 0, 1, 8'h06);
    cyc(0, 0, 0, 0, 0, 8'h00);
    chk("pc6_instr", int'(Instruction), 8'h6A);
    cyc(0, 0, 1, 1, 0, 8'h00);
    chk("halt_pc", int'(InstrPC), 7);
    cyc(0, 0, 1, 0, 1, 8'h30);
    chk("halted_valid", int'(InstrValid), 0);
    chk("halted_busy", int'(Busy), 0);
    chk("halted_addr", int'(RomAddress), 7);
    cyc(0, 1, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 8'h00);
    chk("resume_pc", int'(InstrPC), 7);
    chk("resume_instr", int'(Instruction), 8'h04);
    chk("resume_valid", int'(InstrValid), 1);

    cyc(0, 0, 0, 0, 1, 8'd35);
    cyc(0, 0, 0, 0, 0, 8'h00);
    chk("pc35", int'(InstrPC), 35);
    cyc(0, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 8'h00);
    chk("last_pc", int'(InstrPC), 37);
    chk("last_instr", int'(Instruction), 8'hE0);
    cyc(0, 0, 0, 0, 0, 8'h00);
    chk("done_flag", int'(Done), 1);
    chk("done_valid", int'(InstrValid), 0);
    chk("done_busy", int'(Busy), 0);
    cyc(0, 0, 1, 0, 0, 8'h00);
    chk("done_hold", int'(Done), 1);
    cyc(0, 1, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 8'h00);
    chk("restart_pc", int'(InstrPC), 0);
    chk("restart_valid", int'(InstrValid), 1);

    cyc(0, 0, 0, 0, 1, 8'hFF);
    cyc(0, 0, 0, 0, 0, 8'h00);
    chk("pc255", int'(InstrPC), 255);
    cyc(0, 0, 0, 0, 0, 8'h00);
    chk("wrap_pc", int'(InstrPC), 0);
    chk("wrap_instr", int'(Instruction), 8'h00);
    cyc(1, 0, 0, 0, 0, 8'h00);
    chk("pre_rst_valid", int'(InstrValid), 1);
    cyc(0, 0, 0, 0, 0, 8'h00);
    chk("midrst_valid", int'(InstrValid), 0);
    chk("midrst_addr", int'(RomAddress), 0);
    chk("midrst_busy", int'(Busy), 0);
    chk("midrst_done", int'(Done), 0);

    cyc(0, 1, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 1, 1, 8'h20);
    chk("halt_redir_valid", int'(InstrValid), 0);
    cyc(0, 0, 0, 0, 0, 8'h00);
    chk("halt_redir_addr", int'(RomAddress), 8'h20);
    cyc(0, 1, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 8'h00);
    chk("halt_redir_pc", int'(InstrPC), 8'h20);
    cyc(0, 0, 0, 0, 0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
